// File: rtl/apb2sram.sv
// APB completer that maps each APB transfer onto a single-port SRAM.
// Writes and decode errors complete in the first access cycle; reads wait out the SRAM latency.
module apb2sram #(
    parameter int unsigned     RAW        = 32,
    parameter int unsigned     RW         = 32,
    parameter int unsigned     DEPTH      = 512,
    parameter longint unsigned BASEADDR   = 0,
    parameter int unsigned     RDLAT      = 1,
    parameter int unsigned     PROT_CHECK = 0
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [RAW-1:0]           apb_paddr,
    input  logic [2:0]               apb_pprot,
    input  logic                     apb_psel,
    input  logic                     apb_penable,
    input  logic                     apb_pwrite,
    input  logic [RW-1:0]            apb_pwdata,
    input  logic [RW/8-1:0]          apb_pstrb,
    output logic                     apb_pready,
    output logic [RW-1:0]            apb_prdata,
    output logic                     apb_pslverr,
    output logic                     sram_ce,
    output logic                     sram_we,
    output logic [RW-1:0]            sram_wmask,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic [RW-1:0]            sram_din,
    input  logic [RW-1:0]            sram_dout
);

    localparam int unsigned     SAW = $clog2(DEPTH);
    localparam int unsigned     NB  = RW / 8;
    localparam int unsigned     BSH = $clog2(NB);
    localparam int unsigned     CW  = 4;
    localparam longint unsigned WIN = longint'(DEPTH) * longint'(NB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_pready;
    logic            r_pslverr;
    logic [RW-1:0]   r_prdata;
    logic            r_ce;
    logic            r_we;
    logic [RW-1:0]   r_wmask;
    logic [SAW-1:0]  r_addr;
    logic [RW-1:0]   r_din;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_pready_nxt;
    logic            w_pslverr_nxt;
    logic [RW-1:0]   w_prdata_nxt;
    logic            w_ce_nxt;
    logic            w_we_nxt;
    logic [RW-1:0]   w_wmask_nxt;
    logic [SAW-1:0]  w_addr_nxt;
    logic [RW-1:0]   w_din_nxt;

    logic [RAW-1:0]  w_off;
    logic            w_oor;
    logic            w_misalign;
    logic            w_prot_err;
    logic            w_err;
    logic            w_setup;
    logic [SAW-1:0]  w_word_addr;
    logic [RW-1:0]   w_mask;
    logic            w_unused_prot;

    // Address decode and transfer checks
    always_comb begin
        w_off       = apb_paddr - RAW'(BASEADDR);
        w_oor       = 64'(w_off) >= WIN;
        w_misalign  = |(apb_paddr & RAW'(NB - 1));
        w_prot_err  = (PROT_CHECK != 0) && apb_pwrite && !apb_pprot[0];
        w_err       = w_oor | w_misalign | w_prot_err;
        w_setup     = apb_psel & ~apb_penable;
        w_word_addr = w_off[BSH +: SAW];
        w_mask      = '0;
        for (int i = 0; i < int'(RW); i++) begin
            w_mask[i] = apb_pstrb[i/8];
        end
    end

    assign w_unused_prot = &{1'b0, apb_pprot[2:1]};

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_prdata_nxt  = r_prdata;
        w_ce_nxt      = 1'b0;
        w_we_nxt      = r_we;
        w_wmask_nxt   = r_wmask;
        w_addr_nxt    = r_addr;
        w_din_nxt     = r_din;

        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    if (w_err) begin
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = 1'b1;
                        if (!apb_pwrite) begin
                            w_prdata_nxt = '0;
                        end
                        w_state_nxt = S_RESP;
                    end else if (apb_pwrite) begin
                        w_ce_nxt     = 1'b1;
                        w_we_nxt     = 1'b1;
                        w_wmask_nxt  = w_mask;
                        w_din_nxt    = apb_pwdata;
                        w_addr_nxt   = w_word_addr;
                        w_pready_nxt = 1'b1;
                        w_state_nxt  = S_RESP;
                    end else begin
                        w_ce_nxt    = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_addr_nxt  = w_word_addr;
                        w_cnt_nxt   = CW'(RDLAT);
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The ce cycle itself does not count towards the SRAM latency
                if (!apb_psel) begin
                    w_state_nxt = S_IDLE;
                end else if (!r_ce) begin
                    if (r_cnt == CW'(1)) begin
                        w_prdata_nxt = sram_dout;
                        w_pready_nxt = 1'b1;
                        w_state_nxt  = S_RESP;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_ce      <= 1'b0;
            r_we      <= 1'b0;
            r_wmask   <= '0;
            r_addr    <= '0;
            r_din     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
            r_ce      <= w_ce_nxt;
            r_we      <= w_we_nxt;
            r_wmask   <= w_wmask_nxt;
            r_addr    <= w_addr_nxt;
            r_din     <= w_din_nxt;
        end
    end

    assign apb_pready  = r_pready;
    assign apb_pslverr = r_pslverr;
    assign apb_prdata  = r_prdata;
    assign sram_ce     = r_ce;
    assign sram_we     = r_we;
    assign sram_wmask  = r_wmask;
    assign sram_addr   = r_addr;
    assign sram_din    = r_din;

endmodule

// File: tb/tb_apb2sram.sv
// Scoreboard bench for apb2sram: byte-array reference model, SRAM behavioural model,
// separate monitors for the APB response and the SRAM request side.
module tb_apb2sram;

    localparam int unsigned RDLAT = 3;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned WINB  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        nreset;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        apb_pready, apb_pslverr;
    logic [31:0] apb_prdata;
    logic        sram_ce, sram_we;
    logic [31:0] sram_wmask, sram_din, sram_dout;
    logic [8:0]  sram_addr;

    apb2sram #(
        .RAW(32), .RW(32), .DEPTH(DEPTH), .BASEADDR(0), .RDLAT(RDLAT), .PROT_CHECK(1)
    ) dut (
        .clk(clk), .nreset(nreset),
        .apb_paddr(paddr), .apb_pprot(pprot), .apb_psel(psel), .apb_penable(penable),
        .apb_pwrite(pwrite), .apb_pwdata(pwdata), .apb_pstrb(pstrb),
        .apb_pready(apb_pready), .apb_prdata(apb_prdata), .apb_pslverr(apb_pslverr),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM behavioural model: dout valid RDLAT cycles after ce
    logic [31:0] sram_mem [0:DEPTH-1];
    logic [31:0] rd_pipe  [0:RDLAT-1];
    assign sram_dout = rd_pipe[RDLAT-1];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) | (sram_din & sram_wmask);
            else         rd_pipe[0] <= sram_mem[sram_addr];
        end
        for (int k = 1; k < int'(RDLAT); k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    // Reference model
    logic [7:0]  ref_mem [0:WINB-1];
    logic [31:0] last_rd = '0;

    typedef struct { longint exp_cyc; bit err; logic [31:0] rdata; } resp_t;
    typedef struct { bit we; logic [8:0] addr; logic [31:0] wmask; logic [31:0] din; } sop_t;
    resp_t resp_q[$];
    sop_t  sop_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (nreset && apb_pready) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_pready", 64'(apb_pready), 64'd0);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk("pready_cycle", 64'(cyc), 64'(r.exp_cyc));
                chk("pslverr", 64'(apb_pslverr), 64'(r.err));
                chk("prdata", 64'(apb_prdata), 64'(r.rdata));
            end
        end
    end

    // SRAM request monitor
    logic prev_ce = 1'b0;
    always @(negedge clk) begin
        if (nreset && sram_ce) begin
            if (prev_ce) chk("ce_single_cycle", 64'(prev_ce), 64'd0);
            if (sop_q.size() == 0) begin
                chk("unexpected_ce", 64'(sram_ce), 64'd0);
            end else begin
                sop_t s;
                s = sop_q.pop_front();
                chk("sram_we", 64'(sram_we), 64'(s.we));
                chk("sram_addr", 64'(sram_addr), 64'(s.addr));
                if (s.we) begin
                    chk("sram_wmask", 64'(sram_wmask), 64'(s.wmask));
                    chk("sram_din", 64'(sram_din), 64'(s.din));
                end
            end
        end
        prev_ce = sram_ce;
    end

    // Model a transfer's effect and push its expected responses
    task automatic expect_xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                               input logic [3:0] st, input logic [2:0] pr, input bit resp);
        bit err;
        sop_t s;
        resp_t r;
        int lat;
        err = (a >= WINB) || (a % 4 != 0) || (wr && !pr[0]);
        lat = 1;
        if (err) begin
            if (!wr) last_rd = '0;
        end else begin
            s.we = wr; s.addr = 9'(a / 4); s.din = wd;
            for (int i = 0; i < 32; i++) s.wmask[i] = st[i/8];
            sop_q.push_back(s);
            if (wr) begin
                for (int b = 0; b < 4; b++) if (st[b]) ref_mem[a + b] = wd[8*b +: 8];
            end else begin
                for (int b = 0; b < 4; b++) last_rd[8*b +: 8] = ref_mem[a + b];
                lat = RDLAT + 2;
            end
        end
        if (resp) begin
            r.exp_cyc = cyc + lat; r.err = err; r.rdata = last_rd;
            resp_q.push_back(r);
        end
    endtask

    task automatic setup(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr;
    endtask

    task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr);
        bit got;
        setup(a, wr, wd, st, pr);
        expect_xfer(a, wr, wd, st, pr, 1'b1);
        @(posedge clk); #1;
        penable = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = apb_pready;
        end
        if (!got) chk("pready_timeout", 64'(apb_pready), 64'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_ctl"}, 64'({apb_pready, apb_pslverr, sram_ce, sram_we}), 64'd0);
        chk({name, "_prdata"}, 64'(apb_prdata), 64'd0);
        chk({name, "_wmask"}, 64'(sram_wmask), 64'd0);
        chk({name, "_addr"}, 64'(sram_addr), 64'd0);
        chk({name, "_din"}, 64'(sram_din), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) sram_mem[i] = '0;
        for (int i = 0; i < int'(RDLAT); i++) rd_pipe[i] = '0;
        for (int i = 0; i < int'(WINB); i++) ref_mem[i] = '0;
        nreset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero("reset");
        nreset = 1'b1;
        idle(2);

        // Full write, partial write, read back (back-to-back)
        xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001);
        xfer(32'h10, 1'b1, 32'h11223344, 4'h5, 3'b001);
        xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b001);
        chk("spec_read_value", 64'(apb_prdata), 64'h DE22BE44);
        idle(2);

        // Out-of-range read, misaligned write, then read unchanged data
        xfer(32'h800, 1'b0, 32'h0, 4'h0, 3'b001);
        chk("oor_pslverr", 64'(apb_pslverr), 64'd1);
        chk("oor_prdata", 64'(apb_prdata), 64'd0);
        xfer(32'h12, 1'b1, 32'h55555555, 4'hF, 3'b001);
        xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b001);
        chk("misalign_unchanged", 64'(apb_prdata), 64'h DE22BE44);

        // Protection check on writes
        xfer(32'h20, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000);
        xfer(32'h20, 1'b1, 32'h0BADF00D, 4'hF, 3'b001);
        xfer(32'h20, 1'b0, 32'h0, 4'h0, 3'b000);
        chk("prot_read_value", 64'(apb_prdata), 64'h0BADF00D);
        idle(1);

        // Access phase without a setup phase is ignored
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
        repeat (4) begin
            @(negedge clk);
            chk("no_setup_silent", 64'({apb_pready, sram_ce}), 64'd0);
        end
        idle(1);

        // psel dropped while waiting for read data
        setup(32'h10, 1'b0, 32'h0, 4'h0, 3'b001);
        expect_xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);
        last_rd = 32'h0BADF00D;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_pready", 64'(apb_pready), 64'd0);
        end
        chk("abort_prdata_held", 64'(apb_prdata), 64'h0BADF00D);

        // Reset pulsed mid-read, then a normal read
        setup(32'h10, 1'b0, 32'h0, 4'h0, 3'b001);
        expect_xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 nreset = 1'b0;
        #1 chk_outputs_zero("midreset");
        last_rd = '0;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 nreset = 1'b1;
        xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b001);
        chk("post_reset_read", 64'(apb_prdata), 64'h DE22BE44);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            logic [2:0]  pr;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = WINB + $urandom_range(0, 4095);
            else if (sel == 1) a = 4 * $urandom_range(0, 31) + $urandom_range(1, 3);
            else if (sel == 2) a = 4 * $urandom_range(0, DEPTH - 1);
            else               a = 4 * $urandom_range(0, 31);
            pr = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) != 0)};
            xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), pr);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
        end

        idle(20);
        chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        chk("sram_queue_drained", 64'(sop_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
